prbs26_checker: RTL and testbench
=================================

Name: prbs26_checker

Overview:
- Serial PRBS receiver and checker for the 26-bit Galois pattern generator used in the design. That generator feeds back into stages 1, 2, 8 and 9, and its serial output is stage 26.
- Self-synchronises to the incoming bit stream, declares lock, then counts bit errors.
- Drops lock and resynchronises when the error density gets too high.
- Sits at the far end of a link or loopback, opposite the generator, and provides BER measurement.

Parameters:
- SYNC_CNT, 32: consecutive correct predictions needed to declare lock.
- ERR_WIN, 256: size of the error-density window, in valid bits, while locked.
- ERR_THR, 8: errors within one window that force loss of lock.
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- clr  in  1  synchronous clear of err_cnt (and bit_cnt when enabled).
- din_vld  in  1  din is valid this cycle.
- din  in  1  received serial bit, equal to generator stage 26.
- locked  out  1  checker is locked to the sequence.
- err_pulse  out  1  one-cycle pulse per errored bit while locked.
- sync_loss  out  1  one-cycle pulse when lock is dropped.
- err_cnt  out  CNT_W  saturating count of errored bits while locked.

Behaviour:
- Reset is asynchronous and active-low (rst_n); single clock clk.
- Reset values: locked=0, err_pulse=0, sync_loss=0, err_cnt=0. History register, all counters and state cleared; state=FILL.
- History register h[1:26]: h[1] is the newest bit, h[26] the oldest.
- Predicted bit: p = h[18]^h[19]^h[25]^h[26], i.e. s(t) = s(t-18)^s(t-19)^s(t-25)^s(t-26).
- Cycles with din_vld=0: no state changes except clr; outputs that are pulses go low.
- FILL state:
  - Shift din into h on each valid bit.
  - After the 26th valid bit, go to HUNT with the match count at 0.
- HUNT state, on each valid bit:
  - Compare din with p.
  - If they match and h is not all-zero, increment the match count.
  - If they mismatch, or h is all-zero, clear the match count. An all-zero window never counts as a match, so a stuck-low line never locks.
  - Always shift din into h.
  - When the match count reaches SYNC_CNT, go to LOCKED. locked rises the cycle after that SYNC_CNT-th matching bit is sampled.
- LOCKED state, on each valid bit:
  - Shift p into h, not din, so each line error counts exactly once.
  - On mismatch: err_pulse=1 on the next cycle, err_cnt increments (saturating at all-ones), and the window error count increments.
  - The window counter runs 0..ERR_WIN-1. On wrap, the window error count and window counter clear.
  - When the window error count reaches ERR_THR: sync_loss=1 for one cycle, locked=0, go to FILL, clear h.
  - Loss takes priority over a window wrap in the same cycle.
  - The bit causing loss still produces err_pulse and is counted in err_cnt.
- clr:
  - Zeroes err_cnt on the next edge. clr wins over a coincident error increment.
  - Does not affect lock state, window counters or h.
- Reset asserted mid-operation: immediate return to the reset values; no pulse is emitted.
- err_cnt width: CNT_W. The window counter and window error count are sized by $clog2 of their parameters.

Optional Feature:
- Macro: PRBS26_CHK_BITCNT_EN.
- Defined: adds output bit_cnt, out, 32 bits, counting valid bits checked while locked.
  - Saturates at all-ones.
  - Cleared by clr and by reset.
  - Unchanged on loss of lock, so BER = err_cnt/bit_cnt.
- Undefined: no bit_cnt port and no counter logic; everything else is identical.

Decomposition:
- Package prbs26_pkg holds:
  - PRBS_LEN=26;
  - tap constants TAP_A=18, TAP_B=19, TAP_C=25, TAP_D=26;
  - state typedef with FILL, HUNT and LOCKED.
- One sub-module is natural: prbs26_win_mon. It holds the window counter, window error count and threshold compare, and outputs a loss request. The FSM, history register and err_cnt stay in the top level.

Test Plan:
- Generator seeded 26'h0000001 with din_vld always high. Required: locked rises exactly 26+32=58 valid bits after reset release; no err_pulse over the next 10000 bits.
- Once locked, invert a single bit. Required: exactly one err_pulse, err_cnt=1, locked stays 1, no follow-on errors.
- Inject 8 errors within one 256-bit window. Required: sync_loss pulse on the 8th, err_cnt=8, locked=0; relock after 58 further valid bits.
- Inject 7 errors in window n and 7 in window n+1. Required: no loss, err_cnt=14.
- Constant-zero din for 5000 bits. Required: locked never asserts and the match count stays 0.
- Random din_vld gaps (50% duty) on a clean stream. Required: same lock point counted in valid bits.
- clr coincident with an error pulse. Required: err_cnt=0.
- rst_n dropped mid-lock, asynchronously. Required: outputs go to 0 before the next edge.

Source files
------------

// File: rtl/prbs26_pkg.sv
// Shared constants, state encoding and next-bit predictor for the PRBS26 checker.
package prbs26_pkg;

  localparam int PRBS_LEN = 26;
  localparam int TAP_A    = 18;
  localparam int TAP_B    = 19;
  localparam int TAP_C    = 25;
  localparam int TAP_D    = 26;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // h[1] is the newest received bit, h[PRBS_LEN] the oldest.
  function automatic logic prbs_predict(input logic [PRBS_LEN:1] h);
    return h[TAP_A] ^ h[TAP_B] ^ h[TAP_C] ^ h[TAP_D];
  endfunction

endpackage

// File: rtl/prbs26_win_mon.sv
// Error-density window monitor: counts errors in fixed windows of locked bits and
// requests loss of lock when a window collects ERR_THR errors.
module prbs26_win_mon
  import prbs26_pkg::*;
#(
  parameter int ERR_WIN = 256,
  parameter int ERR_THR = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  input  logic err,
  output logic loss_req
);

  localparam int WW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int EW = (ERR_THR > 1) ? $clog2(ERR_THR) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(ERR_WIN - 1);
  localparam logic [EW-1:0] THR_LAST = EW'(ERR_THR - 1);

  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;

  // The erroring bit that completes the threshold is judged before the window wraps.
  assign loss_req = step && err && (win_err == THR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (step) begin
      if (loss_req || (win_cnt == WIN_LAST)) begin
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        win_err <= win_err + EW'(err);
      end
    end
  end

endmodule

// File: rtl/prbs26_checker.sv
// Self-synchronising PRBS26 receiver/checker with lock detection and BER counting.
// Optional bit_cnt output enabled by defining PRBS26_CHK_BITCNT_EN.
module prbs26_checker
  import prbs26_pkg::*;
#(
  parameter int SYNC_CNT = 32,
  parameter int ERR_WIN  = 256,
  parameter int ERR_THR  = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din_vld,
  input  logic             din,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_loss,
  output logic [CNT_W-1:0] err_cnt
`ifdef PRBS26_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  localparam int FW = $clog2(PRBS_LEN);
  localparam int MW = $clog2(SYNC_CNT + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(PRBS_LEN - 1);
  localparam logic [MW-1:0] SYNC_LAST = MW'(SYNC_CNT - 1);

  state_t            state, state_next;
  logic [PRBS_LEN:1] h, h_next;
  logic [FW-1:0]     fill_cnt, fill_cnt_next;
  logic [MW-1:0]     match_cnt, match_cnt_next;

  logic pred;
  logic mismatch;
  logic h_zero;
  logic lock_step;
  logic loss_req;

  assign pred      = prbs_predict(h);
  assign mismatch  = din ^ pred;
  assign h_zero    = (h == '0);
  assign lock_step = din_vld && (state == LOCKED);
  assign locked    = (state == LOCKED);

  prbs26_win_mon #(
    .ERR_WIN (ERR_WIN),
    .ERR_THR (ERR_THR)
  ) u_win_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (lock_step),
    .err      (mismatch),
    .loss_req (loss_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      h         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
    end else begin
      state     <= state_next;
      h         <= h_next;
      fill_cnt  <= fill_cnt_next;
      match_cnt <= match_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    h_next         = h;
    fill_cnt_next  = fill_cnt;
    match_cnt_next = match_cnt;
    if (din_vld) begin
      case (state)
        FILL: begin
          h_next = {h[PRBS_LEN-1:1], din};
          if (fill_cnt == FILL_LAST) begin
            state_next     = HUNT;
            fill_cnt_next  = '0;
            match_cnt_next = '0;
          end else begin
            fill_cnt_next = fill_cnt + 1'b1;
          end
        end
        HUNT: begin
          h_next = {h[PRBS_LEN-1:1], din};
          // An all-zero window predicts zero forever; never let it count as a match.
          if (!mismatch && !h_zero) begin
            if (match_cnt == SYNC_LAST) begin
              state_next     = LOCKED;
              match_cnt_next = '0;
            end else begin
              match_cnt_next = match_cnt + 1'b1;
            end
          end else begin
            match_cnt_next = '0;
          end
        end
        LOCKED: begin
          if (loss_req) begin
            state_next    = FILL;
            h_next        = '0;
            fill_cnt_next = '0;
          end else begin
            // Free-run on the prediction so a line error is only ever counted once.
            h_next = {h[PRBS_LEN-1:1], pred};
          end
        end
        default: begin
          state_next = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      sync_loss <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= lock_step && mismatch;
      sync_loss <= loss_req;
      if (clr) begin
        err_cnt <= '0;
      end else if (lock_step && mismatch && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

`ifdef PRBS26_CHK_BITCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (lock_step && (bit_cnt != '1)) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prbs26_checker.sv
// Self-checking bench for prbs26_checker: Galois generator as the stimulus source and a
// sequence-level reference model of the checker, compared on every clock.
module tb_prbs26_checker;

  localparam int SYNC_CNT = 32;
  localparam int ERR_WIN  = 256;
  localparam int ERR_THR  = 8;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic din_vld = 1'b0;
  logic din = 1'b0;
  logic locked;
  logic err_pulse;
  logic sync_loss;
  logic [CNT_W-1:0] err_cnt;
`ifdef PRBS26_CHK_BITCNT_EN
  logic [31:0] bit_cnt;
`endif

  always #5 clk = ~clk;

  prbs26_checker #(
    .SYNC_CNT (SYNC_CNT),
    .ERR_WIN  (ERR_WIN),
    .ERR_THR  (ERR_THR),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .din_vld   (din_vld),
    .din       (din),
    .locked    (locked),
    .err_pulse (err_pulse),
    .sync_loss (sync_loss),
    .err_cnt   (err_cnt)
`ifdef PRBS26_CHK_BITCNT_EN
    ,
    .bit_cnt   (bit_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;
  int n_loss   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Galois generator: feedback from stage 26 into stages 1, 2, 8, 9; output is stage 26.
  logic [26:1] gen;

  function automatic logic [26:1] gen_step(input logic [26:1] g);
    logic [26:1] n;
    n = {g[25:1], g[26]};
    n[2] = n[2] ^ g[26];
    n[8] = n[8] ^ g[26];
    n[9] = n[9] ^ g[26];
    return n;
  endfunction

  // Reference model: the last 26 accepted bits as a sequence, predicted by s(t-18)^s(t-19)^s(t-25)^s(t-26).
  int     m_mode;   // 0 fill, 1 hunt, 2 locked
  bit     seq[$];
  int     m_match;
  int     m_winpos;
  int     m_winerr;
  longint m_errcnt;
  longint m_bits;
  bit     e_pulse;
  bit     e_loss;

  task automatic model_reset();
    m_mode = 0; seq.delete(); m_match = 0; m_winpos = 0; m_winerr = 0;
    m_errcnt = 0; m_bits = 0; e_pulse = 0; e_loss = 0;
  endtask

  task automatic model_step(input bit vld, input bit b, input bit c);
    bit pred;
    bit anyone;
    int n;
    e_pulse = 0;
    e_loss  = 0;
    if (vld) begin
      n = seq.size();
      pred = (n >= 26) ? (seq[n-18] ^ seq[n-19] ^ seq[n-25] ^ seq[n-26]) : 1'b0;
      case (m_mode)
        0: begin
          seq.push_back(b);
          if (seq.size() == 26) begin m_mode = 1; m_match = 0; end
        end
        1: begin
          anyone = 0;
          foreach (seq[i]) anyone |= seq[i];
          if (b == pred && anyone) m_match++;
          else m_match = 0;
          seq.push_back(b);
          void'(seq.pop_front());
          if (m_match == SYNC_CNT) begin
            m_mode = 2; m_match = 0; m_winpos = 0; m_winerr = 0;
          end
        end
        default: begin
          seq.push_back(pred);
          void'(seq.pop_front());
          m_bits++;
          if (b != pred) begin
            e_pulse = 1;
            if (m_errcnt < (64'd1 << CNT_W) - 1) m_errcnt++;
            m_winerr++;
          end
          if (m_winerr == ERR_THR) begin
            e_loss = 1; m_mode = 0; seq.delete();
          end else begin
            m_winpos++;
            if (m_winpos == ERR_WIN) begin m_winpos = 0; m_winerr = 0; end
          end
        end
      endcase
    end
    if (c) begin m_errcnt = 0; m_bits = 0; end
  endtask

  // One clock: drive at negedge, advance model, compare just after the rising edge.
  task automatic cyc(input bit vld, input bit b, input bit c);
    @(negedge clk);
    din_vld = vld; din = b; clr = c;
    model_step(vld, b, c);
    @(posedge clk);
    #1;
    chk("locked", locked, (m_mode == 2));
    chk("err_pulse", err_pulse, e_pulse);
    chk("sync_loss", sync_loss, e_loss);
    chk("err_cnt", err_cnt, m_errcnt);
`ifdef PRBS26_CHK_BITCNT_EN
    chk("bit_cnt", bit_cnt, m_bits);
`endif
    if (err_pulse) n_pulses++;
    if (sync_loss) n_loss++;
  endtask

  task automatic send_gen(input bit vld, input bit flip, input bit c);
    bit b;
    if (vld) begin
      b = gen[26] ^ flip;
      gen = gen_step(gen);
    end else begin
      b = 1'($urandom_range(1));
    end
    cyc(vld, b, c);
  endtask

  task automatic do_reset();
    din_vld = 0; din = 0; clr = 0;
    rst_n = 0;
    model_reset();
    gen = 26'h0000001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_sync_loss", sync_loss, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_to_lock(input int duty, input string name);
    int nv;
    bit vld;
    nv = 0;
    for (int i = 0; i < 2000; i++) begin
      vld = ($urandom_range(99) < duty);
      send_gen(vld, 0, 0);
      if (vld) nv++;
      if (locked) break;
    end
    chk(name, nv, 58);
    $display("lock %s: valid bits to lock = %0d", name, nv);
  endtask

  task automatic align_window();
    for (int i = 0; i < ERR_WIN && m_winpos != 0; i++) send_gen(1, 0, 0);
  endtask

  task automatic inject_errs(input int num, input int spacing);
    for (int k = 0; k < num; k++) begin
      for (int j = 0; j < spacing - 1; j++) send_gen(1, 0, 0);
      send_gen(1, 1, 0);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, l0, lk, mc;

    // Pin the model: the first generator outputs from seed 1 are 25 zeros then a one.
    gen = 26'h0000001;
    for (int i = 0; i < 26; i++) begin
      chk("gen_prefix", gen[26], (i == 25));
      gen = gen_step(gen);
    end

    do_reset();
    run_to_lock(100, "lock_clean");

    p0 = n_pulses;
    for (int i = 0; i < 10000; i++) send_gen(1, 0, 0);
    chk("clean_no_pulses", n_pulses - p0, 0);
    chk("clean_err_cnt", err_cnt, 0);
    $display("clean run: 10000 bits, pulses=%0d", n_pulses - p0);

    p0 = n_pulses;
    send_gen(1, 1, 0);
    for (int i = 0; i < 300; i++) send_gen(1, 0, 0);
    chk("single_pulses", n_pulses - p0, 1);
    chk("single_err_cnt", err_cnt, 1);
    chk("single_locked", locked, 1);
    $display("single error: pulses=%0d err_cnt=%0d", n_pulses - p0, err_cnt);

    send_gen(1, 0, 1);
    align_window();
    l0 = n_loss;
    inject_errs(8, 10);
    chk("eight_sync_loss", sync_loss, 1);
    chk("eight_err_cnt", err_cnt, 8);
    chk("eight_locked", locked, 0);
    chk("eight_loss_count", n_loss - l0, 1);
    $display("eight errors: sync_loss=%0d err_cnt=%0d", sync_loss, err_cnt);
    run_to_lock(100, "relock");

    send_gen(1, 0, 1);
    align_window();
    l0 = n_loss;
    inject_errs(7, 30);
    align_window();
    inject_errs(7, 30);
    for (int i = 0; i < 20; i++) send_gen(1, 0, 0);
    chk("seven_seven_err_cnt", err_cnt, 14);
    chk("seven_seven_locked", locked, 1);
    chk("seven_seven_no_loss", n_loss - l0, 0);
    $display("7+7 errors: err_cnt=%0d losses=%0d", err_cnt, n_loss - l0);

    send_gen(1, 1, 1);
    chk("clr_coinc_pulse", err_pulse, 1);
    chk("clr_coinc_err_cnt", err_cnt, 0);
    send_gen(1, 0, 0);
    chk("clr_after_err_cnt", err_cnt, 0);
    $display("clr with error: err_cnt=%0d", err_cnt);

    send_gen(1, 1, 0);
    #1;
    rst_n = 0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_err_pulse", err_pulse, 0);
    chk("async_sync_loss", sync_loss, 0);
    chk("async_err_cnt", err_cnt, 0);
    $display("async reset mid-lock: locked=%0d err_cnt=%0d", locked, err_cnt);

    do_reset();
    run_to_lock(50, "lock_gaps");

    for (int i = 0; i < 4000; i++) begin
      send_gen(($urandom_range(99) < 70), ($urandom_range(49) == 0), ($urandom_range(99) == 0));
    end
    $display("random run: 4000 cycles, pulses=%0d losses=%0d", n_pulses, n_loss);

    do_reset();
    lk = 0;
    mc = 0;
    for (int i = 0; i < 5000; i++) begin
      cyc(1, 0, 0);
      if (locked) lk++;
      if (dut.match_cnt != 0) mc++;
    end
    chk("zero_never_locked", lk, 0);
    chk("zero_match_cnt", mc, 0);
    $display("zero stream: 5000 bits, locked cycles=%0d", lk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
